// File: rtl/instr_mem_responder_pkg.sv
// instr_mem_responder_pkg: FSM state encodings, default NOP word and the fetch address check
package instr_mem_responder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

    // A fetch is bad if it is not word aligned or lies beyond the array.
    function automatic logic fetch_err(input logic [31:0] addr, input int unsigned depth_log2);
        return (addr[1:0] != 2'b00) || ((addr >> (depth_log2 + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/instr_mem_responder_array.sv
// instr_mem_responder_array: program store, one synchronous read port and one write port, read-before-write
//   clk         clock
//   rd_en_i     capture mem[rd_addr_i] into rd_data_o on this edge
//   rd_addr_i   read word address
//   rd_data_o   registered read data
//   we_i        write enable
//   wr_addr_i   write word address
//   wr_data_i   write data
module instr_mem_responder_array #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rd_en_i,
    input  logic [DEPTH_LOG2-1:0] rd_addr_i,
    output logic [31:0]           rd_data_o,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] wr_addr_i,
    input  logic [31:0]           wr_data_i
);

    logic [31:0] mem_q [0:(1<<DEPTH_LOG2)-1];
    logic [31:0] rd_data_q;

    // Both updates are non-blocking, so a same-word read sees the old contents.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[wr_addr_i] <= wr_data_i;
        if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/instr_mem_responder.sv
// instr_mem_responder: answers IF fetches from an internal program array after a fixed latency, stalling IF meanwhile
//   clk               clock
//   rst               asynchronous active-low reset
//   W_req             fetch request valid
//   W_instr_ram_addr  byte address of the requested instruction
//   W_flush           drop the outstanding fetch
//   W_ld_we/addr/data loader write port
//   W_instr           returned instruction
//   W_instr_valid     one-cycle response pulse
//   W_fetch_err       response is for a misaligned or out-of-range address
//   W_stall           fetch in progress, IF holds its PC
module instr_mem_responder
    import instr_mem_responder_pkg::*;
#(
    parameter int          DEPTH_LOG2  = 10,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] NOP_INSTR   = NOP_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  W_req,
    input  logic [31:0]           W_instr_ram_addr,
    input  logic                  W_flush,
    input  logic                  W_ld_we,
    input  logic [DEPTH_LOG2-1:0] W_ld_addr,
    input  logic [31:0]           W_ld_data,
    output logic [31:0]           W_instr,
    output logic                  W_instr_valid,
    output logic                  W_fetch_err,
    output logic                  W_stall
);

    localparam logic [2:0] WAIT_LD = 3'(WAIT_CYCLES);

    logic [1:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        err_q, ok_q;
    logic        accept, enter_resp;
    logic [31:0] rd_data;

    // A request in WAIT is only taken when it comes with a flush (redirect).
    assign accept = W_req && (state_q != ST_WAIT || W_flush);

    always_comb begin
        state_d = accept ? (WAIT_CYCLES != 0 ? ST_WAIT : ST_RESP)
                : (state_q == ST_WAIT) ? (W_flush ? ST_IDLE : (cnt_q == 3'd1 ? ST_RESP : ST_WAIT))
                : ST_IDLE;
        cnt_d   = accept ? WAIT_LD : (state_q == ST_WAIT ? cnt_q - 3'd1 : cnt_q);
        addr_d  = accept ? W_instr_ram_addr : addr_q;
    end

    // With zero wait cycles the read happens on the accept edge, so the
    // array is always addressed from the next-state address.
    assign enter_resp = (state_d == ST_RESP);

    instr_mem_responder_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
        .clk       (clk),
        .rd_en_i   (enter_resp),
        .rd_addr_i (addr_d[DEPTH_LOG2+1:2]),
        .rd_data_o (rd_data),
        .we_i      (W_ld_we),
        .wr_addr_i (W_ld_addr),
        .wr_data_i (W_ld_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            addr_q  <= 32'd0;
            err_q   <= 1'b0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            if (enter_resp) begin
                err_q <= fetch_err(addr_d, DEPTH_LOG2);
                ok_q  <= !fetch_err(addr_d, DEPTH_LOG2);
            end
        end
    end

    // ok_q masks the unreset array register so W_instr reads NOP after reset or on error.
    assign W_instr       = ok_q ? rd_data : NOP_INSTR;
    assign W_instr_valid = (state_q == ST_RESP) && !W_flush;
    assign W_fetch_err   = W_instr_valid && err_q;
    assign W_stall       = (state_q == ST_WAIT) || (accept && WAIT_CYCLES != 0);

    a_no_req_in_wait: assert property (@(posedge clk) disable iff (!rst)
        (state_q == ST_WAIT && !W_flush) |-> !W_req);

endmodule

// File: tb/tb_instr_mem_responder.sv
// tb_instr_mem_responder: scoreboard bench for a WAIT_CYCLES=1 and a WAIT_CYCLES=0 responder
module tb_instr_mem_responder;

    logic        clk = 1'b0;
    logic        rst, req0, req1, flush, ld_we;
    logic [31:0] addr, ld_data;
    logic [9:0]  ld_addr;
    logic [31:0] instr0, instr1;
    logic        valid0, valid1, err0, err1, stall0, stall1;

    logic [31:0] model [0:1023];
    logic [32:0] q0[$], q1[$];
    logic [32:0] exp_r;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    instr_mem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0), .NOP_INSTR(32'h0)) dut0 (
        .clk(clk), .rst(rst), .W_req(req0), .W_instr_ram_addr(addr), .W_flush(flush),
        .W_ld_we(ld_we), .W_ld_addr(ld_addr), .W_ld_data(ld_data),
        .W_instr(instr0), .W_instr_valid(valid0), .W_fetch_err(err0), .W_stall(stall0));

    instr_mem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(1), .NOP_INSTR(32'h0)) dut1 (
        .clk(clk), .rst(rst), .W_req(req1), .W_instr_ram_addr(addr), .W_flush(flush),
        .W_ld_we(ld_we), .W_ld_addr(ld_addr), .W_ld_data(ld_data),
        .W_instr(instr1), .W_instr_valid(valid1), .W_fetch_err(err1), .W_stall(stall1));

    // Expected {fetch_err, instr} for a byte address against the bench's copy of the program.
    function automatic logic [32:0] expect_resp(input logic [31:0] a);
        logic bad;
        bad = (a[1:0] != 2'b00) || (a[31:12] != 20'd0);
        return bad ? {1'b1, 32'h0} : {1'b0, model[a[11:2]]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input int idx, input logic [31:0] d);
        ld_we = 1'b1; ld_addr = idx[9:0]; ld_data = d;
        tick();
        ld_we = 1'b0;
        model[idx] = d;
    endtask

    task automatic test_reset;
        @(negedge clk);
        tests++; if (instr0 !== 32'h0) begin fails++; $display("FAIL reset_instr0 got %h want 00000000", instr0); end
        tests++; if (instr1 !== 32'h0) begin fails++; $display("FAIL reset_instr1 got %h want 00000000", instr1); end
        tests++; if ({valid0, err0, stall0} !== 3'b000) begin fails++; $display("FAIL reset_flags0 got %b want 000", {valid0, err0, stall0}); end
        tests++; if ({valid1, err1, stall1} !== 3'b000) begin fails++; $display("FAIL reset_flags1 got %b want 000", {valid1, err1, stall1}); end
        tick();
        rst = 1'b1;
    endtask

    task automatic test_latency;
        load_word(1, 32'h2008_0005);
        req1 = 1'b1; addr = 32'h4; q1.push_back(expect_resp(32'h4));
        @(negedge clk);
        tests++; if ({stall1, valid1} !== 2'b10) begin fails++; $display("FAIL lat_t0 stall,valid got %b want 10", {stall1, valid1}); end
        tick();
        req1 = 1'b0;
        @(negedge clk);
        tests++; if ({stall1, valid1} !== 2'b10) begin fails++; $display("FAIL lat_t1 stall,valid got %b want 10", {stall1, valid1}); end
        tick();
        @(negedge clk);
        tests++; if ({stall1, valid1} !== 2'b01) begin fails++; $display("FAIL lat_t2 stall,valid got %b want 01", {stall1, valid1}); end
        if (q1.size() != 0) begin
            exp_r = q1.pop_front();
            tests++; if (instr1 !== exp_r[31:0]) begin fails++; $display("FAIL lat_data got %h want %h", instr1, exp_r[31:0]); end
            tests++; if (err1 !== exp_r[32]) begin fails++; $display("FAIL lat_err got %b want %b", err1, exp_r[32]); end
        end
        tick();
        @(negedge clk);
        tests++; if (valid1 !== 1'b0) begin fails++; $display("FAIL lat_t3 valid got %b want 0", valid1); end
        tick();
    endtask

    task automatic test_back_to_back;
        load_word(0, 32'h0000_00A0);
        load_word(2, 32'h0000_00A8);
        for (int i = 0; i < 4; i++) begin
            req0 = (i < 3);
            addr = 32'(i * 4);
            if (i < 3) q0.push_back(expect_resp(32'(i * 4)));
            @(negedge clk);
            tests++; if (stall0 !== 1'b0) begin fails++; $display("FAIL b2b_stall[%0d] got %b want 0", i, stall0); end
            if (i == 0) begin
                tests++; if (valid0 !== 1'b0) begin fails++; $display("FAIL b2b_valid[0] got %b want 0", valid0); end
            end else begin
                tests++; if (valid0 !== 1'b1) begin fails++; $display("FAIL b2b_valid[%0d] got %b want 1", i, valid0); end
                exp_r = q0.pop_front();
                tests++; if (instr0 !== exp_r[31:0]) begin fails++; $display("FAIL b2b_data[%0d] got %h want %h", i, instr0, exp_r[31:0]); end
            end
            tick();
        end
        req0 = 1'b0;
        @(negedge clk);
        tests++; if (valid0 !== 1'b0 || q0.size() != 0) begin fails++; $display("FAIL b2b_end valid %b pending %0d want 0 0", valid0, q0.size()); end
        tick();
    endtask

    task automatic test_fetch_err;
        logic [31:0] bad [2];
        logic seen;
        bad[0] = 32'h0000_0006;
        bad[1] = 32'h0000_1000;
        for (int j = 0; j < 2; j++) begin
            req1 = 1'b1; addr = bad[j]; q1.push_back(expect_resp(bad[j]));
            tick();
            req1 = 1'b0;
            seen = 1'b0;
            for (int k = 0; k < 4 && !seen; k++) begin
                @(negedge clk);
                if (valid1 === 1'b1) begin
                    seen = 1'b1;
                    exp_r = q1.pop_front();
                    tests++; if (instr1 !== exp_r[31:0]) begin fails++; $display("FAIL err_data[%0d] got %h want %h", j, instr1, exp_r[31:0]); end
                    tests++; if (err1 !== exp_r[32]) begin fails++; $display("FAIL err_flag[%0d] got %b want %b", j, err1, exp_r[32]); end
                end else begin
                    tests++; if (err1 !== 1'b0) begin fails++; $display("FAIL err_unqualified[%0d] got %b want 0", j, err1); end
                end
                tick();
            end
            tests++; if (!seen) begin fails++; $display("FAIL err_timeout[%0d] valid got 0 want 1", j); end
        end
    endtask

    task automatic test_flush;
        load_word(2, 32'h2222_0008);
        req1 = 1'b1; addr = 32'h4;
        tick();
        req1 = 1'b0; flush = 1'b1;
        @(negedge clk);
        tests++; if (valid1 !== 1'b0) begin fails++; $display("FAIL flush_wait_valid got %b want 0", valid1); end
        tick();
        flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests++; if ({valid1, stall1} !== 2'b00) begin fails++; $display("FAIL flush_idle[%0d] valid,stall got %b want 00", k, {valid1, stall1}); end
            tick();
        end
        req1 = 1'b1; addr = 32'h0;
        tick();
        flush = 1'b1; addr = 32'h8; q1.push_back(expect_resp(32'h8));
        @(negedge clk);
        tests++; if (stall1 !== 1'b1) begin fails++; $display("FAIL flush_redirect_stall got %b want 1", stall1); end
        tick();
        flush = 1'b0; req1 = 1'b0;
        @(negedge clk);
        tests++; if ({valid1, stall1} !== 2'b01) begin fails++; $display("FAIL flush_redirect_wait valid,stall got %b want 01", {valid1, stall1}); end
        tick();
        @(negedge clk);
        tests++; if (valid1 !== 1'b1) begin fails++; $display("FAIL flush_redirect_valid got %b want 1", valid1); end
        exp_r = q1.pop_front();
        tests++; if (instr1 !== exp_r[31:0]) begin fails++; $display("FAIL flush_redirect_data got %h want %h", instr1, exp_r[31:0]); end
        tick();
        @(negedge clk);
        tests++; if (valid1 !== 1'b0 || q1.size() != 0) begin fails++; $display("FAIL flush_end valid %b pending %0d want 0 0", valid1, q1.size()); end
        tick();
    endtask

    task automatic test_rbw;
        load_word(3, 32'h3333_000C);
        req1 = 1'b1; addr = 32'hC; q1.push_back(expect_resp(32'hC));
        tick();
        req1 = 1'b0; ld_we = 1'b1; ld_addr = 10'd3; ld_data = 32'hDEAD_BEEF;
        tick();
        ld_we = 1'b0; model[3] = 32'hDEAD_BEEF;
        @(negedge clk);
        tests++; if (valid1 !== 1'b1) begin fails++; $display("FAIL rbw_valid got %b want 1", valid1); end
        exp_r = q1.pop_front();
        tests++; if (instr1 !== exp_r[31:0]) begin fails++; $display("FAIL rbw_old_data got %h want %h", instr1, exp_r[31:0]); end
        tick();
        req1 = 1'b1; addr = 32'hC; q1.push_back(expect_resp(32'hC));
        tick();
        req1 = 1'b0;
        tick();
        @(negedge clk);
        tests++; if (valid1 !== 1'b1) begin fails++; $display("FAIL rbw_refetch_valid got %b want 1", valid1); end
        exp_r = q1.pop_front();
        tests++; if (instr1 !== exp_r[31:0]) begin fails++; $display("FAIL rbw_new_data got %h want %h", instr1, exp_r[31:0]); end
        tick();
    endtask

    task automatic test_reset_mid_fetch;
        req1 = 1'b1; addr = 32'h4;
        tick();
        req1 = 1'b0;
        rst = 1'b0;
        #1;
        tests++; if (instr1 !== 32'h0) begin fails++; $display("FAIL midrst_instr got %h want 00000000", instr1); end
        tests++; if ({valid1, err1, stall1} !== 3'b000) begin fails++; $display("FAIL midrst_flags got %b want 000", {valid1, err1, stall1}); end
        tick();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tests++; if (valid1 !== 1'b0) begin fails++; $display("FAIL midrst_ghost[%0d] valid got %b want 0", k, valid1); end
            tick();
        end
    endtask

    initial begin
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0; flush = 1'b0;
        ld_we = 1'b0; addr = 32'h0; ld_addr = 10'd0; ld_data = 32'h0;
        test_reset();
        test_latency();
        test_back_to_back();
        test_fetch_err();
        test_flush();
        test_rbw();
        test_reset_mid_fetch();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
